// File: rtl/dct_pkg.sv
// Shared definitions for the 8-point HEVC forward DCT: widths, signed
// datapath types and the core-transform coefficients.
package dct_pkg;

  localparam int WIDTH_X_DEF = 9;                // input sample width
  localparam int WIDTH_Y_DEF = 19;               // output coefficient width
  localparam int WIDTH_B     = WIDTH_X_DEF + 1;  // e/o butterfly width
  localparam int WIDTH_BB    = WIDTH_X_DEF + 2;  // ee/eo butterfly width

  typedef logic signed [WIDTH_X_DEF-1:0] sample_t;
  typedef logic signed [WIDTH_B-1:0]     bfly_t;
  typedef logic signed [WIDTH_BB-1:0]    bfly2_t;
  typedef logic signed [WIDTH_Y_DEF-1:0] coef_t;

  // HEVC 8-point core transform coefficients
  localparam coef_t C64 = 19'sd64;
  localparam coef_t C83 = 19'sd83;
  localparam coef_t C36 = 19'sd36;
  localparam coef_t C89 = 19'sd89;
  localparam coef_t C75 = 19'sd75;
  localparam coef_t C50 = 19'sd50;
  localparam coef_t C18 = 19'sd18;

endpackage

// File: rtl/dct_8puntos_odd.sv
// Odd half of the 8-point DCT: 4x4 matrix from the difference terms
// o0..o3 to the odd coefficients y1, y3, y5, y7. Purely combinational;
// the caller registers the results.
module dct_8puntos_odd
  import dct_pkg::*;
(
  input  logic signed [WIDTH_B-1:0]     o0_i,
  input  logic signed [WIDTH_B-1:0]     o1_i,
  input  logic signed [WIDTH_B-1:0]     o2_i,
  input  logic signed [WIDTH_B-1:0]     o3_i,
  output logic signed [WIDTH_Y_DEF-1:0] y1_o,
  output logic signed [WIDTH_Y_DEF-1:0] y3_o,
  output logic signed [WIDTH_Y_DEF-1:0] y5_o,
  output logic signed [WIDTH_Y_DEF-1:0] y7_o
);

  coef_t s0, s1, s2, s3;

  // Sign-extend to full coefficient width first so no product or sum wraps
  always_comb begin
    s0 = coef_t'(o0_i);
    s1 = coef_t'(o1_i);
    s2 = coef_t'(o2_i);
    s3 = coef_t'(o3_i);
    y1_o = C89 * s0 + C75 * s1 + C50 * s2 + C18 * s3;
    y3_o = C75 * s0 - C18 * s1 - C89 * s2 - C50 * s3;
    y5_o = C50 * s0 - C89 * s1 + C18 * s2 + C75 * s3;
    y7_o = C18 * s0 - C50 * s1 + C75 * s2 - C89 * s3;
  end

endmodule

// File: rtl/dct_8puntos.sv
// 8-point forward integer DCT (HEVC core matrix), full precision.
// Three stages: input capture on load, butterflies, output coefficients.
// A vector captured at edge N is visible on y0..y7 after edge N+2.
module dct_8puntos
  import dct_pkg::*;
#(
  parameter int WIDTH_X = WIDTH_X_DEF,
  parameter int WIDTH_Y = WIDTH_Y_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic signed [WIDTH_X-1:0] x0,
  input  logic signed [WIDTH_X-1:0] x1,
  input  logic signed [WIDTH_X-1:0] x2,
  input  logic signed [WIDTH_X-1:0] x3,
  input  logic signed [WIDTH_X-1:0] x4,
  input  logic signed [WIDTH_X-1:0] x5,
  input  logic signed [WIDTH_X-1:0] x6,
  input  logic signed [WIDTH_X-1:0] x7,
  output logic signed [WIDTH_Y-1:0] y0,
  output logic signed [WIDTH_Y-1:0] y1,
  output logic signed [WIDTH_Y-1:0] y2,
  output logic signed [WIDTH_Y-1:0] y3,
  output logic signed [WIDTH_Y-1:0] y4,
  output logic signed [WIDTH_Y-1:0] y5,
  output logic signed [WIDTH_Y-1:0] y6,
  output logic signed [WIDTH_Y-1:0] y7
);

  // Stage 1: captured samples
  sample_t x_q [8];

  // Stage 2: butterfly results
  bfly_t  e_d [4];
  bfly_t  o_d [4];
  bfly_t  o_q [4];
  bfly2_t ee0_d, ee1_d, eo0_d, eo1_d;
  bfly2_t ee0_q, ee1_q, eo0_q, eo1_q;

  // Stage 3: output coefficients
  coef_t y_d [8];
  coef_t y_q [8];
  coef_t y1_odd, y3_odd, y5_odd, y7_odd;

  // Capture the input vector on load; reset wins over load
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every pipeline register is cleared so a reset discards all
      // in-flight vectors; the all-zero state transforms to zero outputs.
      for (int i = 0; i < 8; i++) x_q[i] <= '0;
    end else if (load) begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value regardless of statement order.
      x_q[0] <= sample_t'(x0);
      x_q[1] <= sample_t'(x1);
      x_q[2] <= sample_t'(x2);
      x_q[3] <= sample_t'(x3);
      x_q[4] <= sample_t'(x4);
      x_q[5] <= sample_t'(x5);
      x_q[6] <= sample_t'(x6);
      x_q[7] <= sample_t'(x7);
    end
  end

  // Sum/difference butterflies with one bit of growth per level
  always_comb begin
    // NOTE: every output gets a value on every pass, so no latch is inferred.
    for (int i = 0; i < 4; i++) begin
      e_d[i] = bfly_t'(x_q[i]) + bfly_t'(x_q[7-i]);
      o_d[i] = bfly_t'(x_q[i]) - bfly_t'(x_q[7-i]);
    end
    ee0_d = bfly2_t'(e_d[0]) + bfly2_t'(e_d[3]);
    ee1_d = bfly2_t'(e_d[1]) + bfly2_t'(e_d[2]);
    eo0_d = bfly2_t'(e_d[0]) - bfly2_t'(e_d[3]);
    eo1_d = bfly2_t'(e_d[1]) - bfly2_t'(e_d[2]);
  end

  // Butterfly register stage, free-running
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) o_q[i] <= '0;
      ee0_q <= '0;
      ee1_q <= '0;
      eo0_q <= '0;
      eo1_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) o_q[i] <= o_d[i];
      ee0_q <= ee0_d;
      ee1_q <= ee1_d;
      eo0_q <= eo0_d;
      eo1_q <= eo1_d;
    end
  end

  dct_8puntos_odd u_odd (
    .o0_i (o_q[0]),
    .o1_i (o_q[1]),
    .o2_i (o_q[2]),
    .o3_i (o_q[3]),
    .y1_o (y1_odd),
    .y3_o (y3_odd),
    .y5_o (y5_odd),
    .y7_o (y7_odd)
  );

  // Even coefficients inline, odd ones from the sub-module
  always_comb begin
    y_d[0] = C64 * (coef_t'(ee0_q) + coef_t'(ee1_q));
    y_d[4] = C64 * (coef_t'(ee0_q) - coef_t'(ee1_q));
    y_d[2] = C83 * coef_t'(eo0_q) + C36 * coef_t'(eo1_q);
    y_d[6] = C36 * coef_t'(eo0_q) - C83 * coef_t'(eo1_q);
    y_d[1] = y1_odd;
    y_d[3] = y3_odd;
    y_d[5] = y5_odd;
    y_d[7] = y7_odd;
  end

  // Output register stage, free-running
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) y_q[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) y_q[i] <= y_d[i];
    end
  end

  assign y0 = y_q[0];
  assign y1 = y_q[1];
  assign y2 = y_q[2];
  assign y3 = y_q[3];
  assign y4 = y_q[4];
  assign y5 = y_q[5];
  assign y6 = y_q[6];
  assign y7 = y_q[7];

endmodule

// File: tb/tb_dct_8puntos.sv
// Directed bench for dct_8puntos: reset, latency, constant pipeline,
// impulse, alternating, extremes, hold and mid-pipeline reset.
module tb_dct_8puntos;

  logic        clk;
  logic        rst;
  logic        load;
  logic [8:0]  xv [8];
  logic [18:0] y0, y1, y2, y3, y4, y5, y6, y7;

  int total;
  int bad;
  int exp_v [8];

  // HEVC 8x8 forward matrix, row k = coefficient k
  localparam int T [8][8] = '{
    '{64,  64,  64,  64,  64,  64,  64,  64},
    '{89,  75,  50,  18, -18, -50, -75, -89},
    '{83,  36, -36, -83, -83, -36,  36,  83},
    '{75, -18, -89, -50,  50,  89,  18, -75},
    '{64, -64, -64,  64,  64, -64, -64,  64},
    '{50, -89,  18,  75, -75, -18,  89, -50},
    '{36, -83,  83, -36, -36,  83, -83,  36},
    '{18, -50,  75, -89,  89, -75,  50, -18}
  };

  dct_8puntos dut (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .x0   (xv[0]),
    .x1   (xv[1]),
    .x2   (xv[2]),
    .x3   (xv[3]),
    .x4   (xv[4]),
    .x5   (xv[5]),
    .x6   (xv[6]),
    .x7   (xv[7]),
    .y0   (y0),
    .y1   (y1),
    .y2   (y2),
    .y3   (y3),
    .y4   (y4),
    .y5   (y5),
    .y6   (y6),
    .y7   (y7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [18:0] obs, input int expv);
    logic [18:0] e;
    e = expv[18:0];
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(e));
    end
  endtask

  task automatic check_vec(input string tag);
    logic [18:0] ys [8];
    ys = '{y0, y1, y2, y3, y4, y5, y6, y7};
    for (int k = 0; k < 8; k++)
      check($sformatf("%s.y%0d", tag, k), ys[k], exp_v[k]);
  endtask

  task automatic set_exp(input int a0, input int a1, input int a2, input int a3,
                         input int a4, input int a5, input int a6, input int a7);
    exp_v = '{a0, a1, a2, a3, a4, a5, a6, a7};
  endtask

  task automatic set_x(input int a0, input int a1, input int a2, input int a3,
                       input int a4, input int a5, input int a6, input int a7);
    xv[0] = 9'(a0); xv[1] = 9'(a1); xv[2] = 9'(a2); xv[3] = 9'(a3);
    xv[4] = 9'(a4); xv[5] = 9'(a5); xv[6] = 9'(a6); xv[7] = 9'(a7);
  endtask

  // Reference: direct matrix-vector product of the current drive values
  task automatic model_exp();
    for (int k = 0; k < 8; k++) begin
      exp_v[k] = 0;
      for (int n = 0; n < 8; n++)
        exp_v[k] += T[k][n] * int'($signed(xv[n]));
    end
  endtask

  // Load the current x for one edge, then let it reach the outputs
  task automatic run_vec();
    load = 1'b1;
    step();
    load = 1'b0;
    step();
    step();
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Reset held two edges with load=1 and nonzero inputs
    rst  = 1'b1;
    load = 1'b1;
    set_x(5, 5, 5, 5, 5, 5, 5, 5);
    step();
    step();
    rst  = 1'b0;
    load = 1'b0;
    set_exp(0, 0, 0, 0, 0, 0, 0, 0);
    check_vec("reset");

    // First load: impulse, outputs stay 0 until two edges after capture
    set_x(1, 0, 0, 0, 0, 0, 0, 0);
    load = 1'b1;
    step();
    load = 1'b0;
    check_vec("lat1");
    step();
    check_vec("lat2");
    step();
    set_exp(64, 89, 83, 75, 64, 50, 36, 18);
    check_vec("impulse");

    // Constant pipeline, back-to-back loads
    set_x(-256, -256, -256, -256, -256, -256, -256, -256);
    load = 1'b1;
    step();
    set_x(2, 2, 2, 2, 2, 2, 2, 2);
    step();
    set_x(3, 3, 3, 3, 3, 3, 3, 3);
    step();
    load = 1'b0;
    set_exp(-131072, 0, 0, 0, 0, 0, 0, 0);
    check_vec("const_m256");
    check("const_m256.hex", y0, 'h60000);
    step();
    set_exp(1024, 0, 0, 0, 0, 0, 0, 0);
    check_vec("const_2");
    step();
    set_exp(1536, 0, 0, 0, 0, 0, 0, 0);
    check_vec("const_3");
    step();
    check_vec("const_3_hold");

    // Alternating signs
    set_x(1, -1, 1, -1, 1, -1, 1, -1);
    run_vec();
    set_exp(0, 92, 0, 108, 0, 164, 0, 464);
    check_vec("alt");

    // All at positive full scale
    set_x(255, 255, 255, 255, 255, 255, 255, 255);
    run_vec();
    set_exp(130560, 0, 0, 0, 0, 0, 0, 0);
    check_vec("max_pos");

    // Full-range odd sums: hand values and matrix model
    set_x(255, 255, 255, 255, -256, -256, -256, -256);
    run_vec();
    set_exp(-256, 118552, 0, -41902, 0, 27594, 0, -23506);
    check_vec("mixed_hand");
    model_exp();
    check_vec("mixed_model");

    // Hold: load=0 while x toggles, outputs keep the mixed result
    set_exp(-256, 118552, 0, -41902, 0, 27594, 0, -23506);
    for (int c = 0; c < 4; c++) begin
      for (int n = 0; n < 8; n++) xv[n] = 9'($urandom);
      step();
      check_vec($sformatf("hold%0d", c));
    end

    // Arbitrary vector against the matrix model
    set_x(-17, 100, -200, 33, 250, -1, 77, -128);
    model_exp();
    run_vec();
    check_vec("model_vec");

    // Reset one edge after a load: that vector never appears
    set_x(1, 0, 0, 0, 0, 0, 0, 0);
    load = 1'b1;
    step();
    load = 1'b0;
    rst  = 1'b1;
    step();
    rst  = 1'b0;
    set_exp(0, 0, 0, 0, 0, 0, 0, 0);
    check_vec("midrst0");
    step();
    check_vec("midrst1");
    step();
    check_vec("midrst2");

    // Load during reset is ignored
    set_x(255, 255, 255, 255, 255, 255, 255, 255);
    rst  = 1'b1;
    load = 1'b1;
    step();
    rst  = 1'b0;
    load = 1'b0;
    step();
    step();
    step();
    check_vec("load_in_rst");

    // Pipeline still works after reset
    set_x(1, -1, 1, -1, 1, -1, 1, -1);
    run_vec();
    set_exp(0, 92, 0, 108, 0, 164, 0, 464);
    check_vec("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
